fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: walks a program ROM from START_ADDR, issuing one
// {operator, operand} pair at a time over a valid/ready handshake.
// Each instruction costs one FETCH cycle (combinational ROM read,
// HALT detection) and at least one ISSUE cycle (held until accepted).
// A handshake may redirect the PC. A target past the end of the program
// finishes the run with a sticky error flag instead of wrapping.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    PROG_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] START_ADDR = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_OP    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_operator,
    input  logic [DATA_WIDTH-1:0] rom_operand,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_operator,
    output logic [DATA_WIDTH-1:0] instr_operand,
    input  logic                  jump_valid,
    input  logic [DATA_WIDTH-1:0] jump_addr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] issue_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The next-PC compare uses one extra bit, so pc+1 at the top of the
    // address space reads as out of range instead of wrapping to zero.
    localparam logic [DATA_WIDTH:0] LP_DEPTH = (DATA_WIDTH+1)'(PROG_DEPTH);
    localparam logic [DATA_WIDTH:0] LP_ONE   = {{DATA_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_op;
    logic [DATA_WIDTH-1:0] r_opnd;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_cnt;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] w_op_nxt;
    logic [DATA_WIDTH-1:0] w_opnd_nxt;
    logic                  w_err_nxt;
    logic [DATA_WIDTH-1:0] w_cnt_nxt;

    logic                  w_hs;
    logic [DATA_WIDTH:0]   w_tgt_ext;
    logic                  w_tgt_oob;

    // Handshake and redirect target. jump_valid only matters when w_hs is set.
    always_comb begin
        w_hs      = (r_state == ISSUE) && instr_ready;
        w_tgt_ext = jump_valid ? {1'b0, jump_addr} : ({1'b0, r_pc} + LP_ONE);
        w_tgt_oob = (w_tgt_ext >= LP_DEPTH);
    end

    // Next-state and datapath update. Abort overrides every transition,
    // but a handshake in the same cycle is still counted.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_op_nxt    = r_op;
        w_opnd_nxt  = r_opnd;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        if (w_hs) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_state_nxt = FETCH;
                        w_pc_nxt    = START_ADDR;
                        w_err_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                FETCH: begin
                    if (rom_operator == HALT_OP) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_op_nxt    = rom_operator;
                        w_opnd_nxt  = rom_operand;
                    end
                end
                ISSUE: begin
                    if (w_hs) begin
                        if (w_tgt_oob) begin
                            // PC keeps the last issued address for debug.
                            w_state_nxt = DONE;
                            w_err_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = FETCH;
                            w_pc_nxt    = w_tgt_ext[DATA_WIDTH-1:0];
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: PC, latched instruction, error flag, issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= '0;
            r_op   <= '0;
            r_opnd <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_op   <= w_op_nxt;
            r_opnd <= w_opnd_nxt;
            r_err  <= w_err_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Outputs decode registered state only. Reset therefore clears them
    // without waiting for a clock edge.
    always_comb begin
        rom_addr       = r_pc;
        pc             = r_pc;
        instr_valid    = (r_state == ISSUE);
        instr_operator = r_op;
        instr_operand  = r_opnd;
        busy           = (r_state == FETCH) || (r_state == ISSUE);
        done           = (r_state == DONE);
        err            = r_err;
        issue_count    = r_cnt;
    end

endmodule
